ex_flag_stage: RTL and testbench

- Pipeline register that sits directly downstream of the 16-bit saturating add/sub and the rest of the EX-stage ALU.
- Captures the ALU result and its writeback control into the EX/MEM boundary.
- Computes the Z, V and N condition flags and holds them in the architectural flag register.
- Supports stall (hold) and flush (bubble insertion) from the hazard unit.

---
 rtl/ex_flag_stage.sv | 96 +++++++++
 tb/tb_ex_flag_stage.sv | 170 +++++++++++++++++
 2 files changed

// File: rtl/ex_flag_stage.sv
// EX/MEM pipeline register with Z/V/N flag register; FLAG_BYPASS_EN makes flags show same-cycle updates.
// Latency: 1 cycle in_* -> out_*; flags 1 cycle (0 cycles with FLAG_BYPASS_EN).
// Backpressure: stall holds all state, flush inserts a bubble leaving flags untouched; rst > flush > stall.
module ex_flag_stage #(
  parameter int DW = 16,
  parameter int RW = 4
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          stall,
  input  logic          flush,
  input  logic          in_valid,
  input  logic [3:0]    in_op,
  input  logic [DW-1:0] in_result,
  input  logic          in_ovfl,
  input  logic [RW-1:0] in_dst,
  input  logic          in_wen,
  output logic          out_valid,
  output logic [DW-1:0] out_result,
  output logic [RW-1:0] out_dst,
  output logic          out_wen,
  output logic          flag_z,
  output logic          flag_v,
  output logic          flag_n
);

  localparam logic [3:0] OP_ADD = 4'b0000;
  localparam logic [3:0] OP_SUB = 4'b0001;
  localparam logic [3:0] OP_XOR = 4'b0010;

  typedef struct packed {
    logic          vld;
    logic [DW-1:0] result;
    logic [RW-1:0] dst;
    logic          wen;
  } pipe_t;

  pipe_t pipe_q;
  logic  z_q, v_q, n_q;
  logic  z_d, v_d, n_d;
  logic  flag_upd;

  assign flag_upd = !rst && !flush && !stall && in_valid;

  // Next-flag values equal the held values unless this cycle updates them.
  always_comb begin
    z_d = z_q;
    v_d = v_q;
    n_d = n_q;
    if (flag_upd) begin
      if (in_op == OP_ADD || in_op == OP_SUB) begin
        z_d = (in_result == '0);
        n_d = in_result[DW-1];
        v_d = in_ovfl;
      end else if (in_op == OP_XOR) begin
        z_d = (in_result == '0);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      pipe_q <= '0;
      z_q    <= 1'b0;
      v_q    <= 1'b0;
      n_q    <= 1'b0;
    end else if (flush) begin
      pipe_q.vld <= 1'b0;
      pipe_q.wen <= 1'b0;
    end else if (!stall) begin
      pipe_q.vld    <= in_valid;
      pipe_q.result <= in_result;
      pipe_q.dst    <= in_dst;
      pipe_q.wen    <= in_wen & in_valid;
      z_q           <= z_d;
      v_q           <= v_d;
      n_q           <= n_d;
    end
  end

  assign out_valid  = pipe_q.vld;
  assign out_result = pipe_q.result;
  assign out_dst    = pipe_q.dst;
  assign out_wen    = pipe_q.wen;

`ifdef FLAG_BYPASS_EN
  assign flag_z = z_d;
  assign flag_v = v_d;
  assign flag_n = n_d;
`else
  assign flag_z = z_q;
  assign flag_v = v_q;
  assign flag_n = n_q;
`endif

endmodule

// File: tb/tb_ex_flag_stage.sv
// Bench for ex_flag_stage: behavioural model compared every negedge plus hand-computed directed checks.
module tb_ex_flag_stage;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        stall = 1'b0;
  logic        flush = 1'b0;
  logic        in_valid = 1'b0;
  logic [3:0]  in_op = 4'h0;
  logic [15:0] in_result = 16'h0;
  logic        in_ovfl = 1'b0;
  logic [3:0]  in_dst = 4'h0;
  logic        in_wen = 1'b0;
  logic        out_valid, out_wen, flag_z, flag_v, flag_n;
  logic [15:0] out_result;
  logic [3:0]  out_dst;

  int checks = 0;
  int errors = 0;

  ex_flag_stage #(.DW(16), .RW(4)) dut (
    .clk(clk), .rst(rst), .stall(stall), .flush(flush),
    .in_valid(in_valid), .in_op(in_op), .in_result(in_result),
    .in_ovfl(in_ovfl), .in_dst(in_dst), .in_wen(in_wen),
    .out_valid(out_valid), .out_result(out_result), .out_dst(out_dst),
    .out_wen(out_wen), .flag_z(flag_z), .flag_v(flag_v), .flag_n(flag_n)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  // Model state: architectural view of the stage (pipeline word + {z,v,n}).
  logic        m_valid, m_wen;
  logic [15:0] m_result;
  logic [3:0]  m_dst;
  logic [2:0]  m_flags;

  // Flags after an instruction retires with in_valid=1; {z,v,n}.
  function automatic logic [2:0] flags_after(input logic [3:0] op, input logic [15:0] res,
                                             input logic ovfl, input logic [2:0] cur);
    case (op)
      4'd0, 4'd1: return {res == 16'h0, ovfl, res[15]};
      4'd2:       return {res == 16'h0, cur[1], cur[0]};
      default:    return cur;
    endcase
  endfunction

  always @(posedge clk) begin
    if (rst) begin
      {m_valid, m_wen, m_result, m_dst, m_flags} = '0;
    end else if (flush) begin
      m_valid = 1'b0;
      m_wen   = 1'b0;
    end else if (!stall) begin
      m_valid  = in_valid;
      m_wen    = in_wen && in_valid;
      m_result = in_result;
      m_dst    = in_dst;
      if (in_valid) m_flags = flags_after(in_op, in_result, in_ovfl, m_flags);
    end
  end

  function automatic logic [2:0] visible_flags();
`ifdef FLAG_BYPASS_EN
    if (!rst && !flush && !stall && in_valid)
      return flags_after(in_op, in_result, in_ovfl, m_flags);
`endif
    return m_flags;
  endfunction

  always @(negedge clk) begin
    logic [2:0] f;
    f = visible_flags();
    chk("model out_valid",  {31'd0, out_valid}, {31'd0, m_valid});
    chk("model out_wen",    {31'd0, out_wen},   {31'd0, m_wen});
    chk("model out_result", {16'd0, out_result}, {16'd0, m_result});
    chk("model out_dst",    {28'd0, out_dst},   {28'd0, m_dst});
    chk("model flags",      {29'd0, flag_z, flag_v, flag_n}, {29'd0, f});
  end

  // Present one cycle of inputs, clock it, then return to idle inputs 1ns after the edge.
  task automatic cyc(input logic r, input logic st, input logic fl, input logic v,
                     input logic [3:0] op, input logic [15:0] res, input logic ov,
                     input logic [3:0] dst, input logic we);
    rst = r; stall = st; flush = fl; in_valid = v; in_op = op;
    in_result = res; in_ovfl = ov; in_dst = dst; in_wen = we;
    @(posedge clk);
    #1;
    rst = 0; stall = 0; flush = 0; in_valid = 0; in_op = 4'hF;
    in_ovfl = 0; in_wen = 0;
  endtask

  task automatic chk_state(input string nm, input logic v, input logic we, input logic [15:0] res,
                           input logic [3:0] dst, input logic [2:0] zvn);
    chk({nm, " out_valid"},  {31'd0, out_valid}, {31'd0, v});
    chk({nm, " out_wen"},    {31'd0, out_wen},   {31'd0, we});
    chk({nm, " out_result"}, {16'd0, out_result}, {16'd0, res});
    chk({nm, " out_dst"},    {28'd0, out_dst},   {28'd0, dst});
    chk({nm, " zvn"},        {29'd0, flag_z, flag_v, flag_n}, {29'd0, zvn});
  endtask

  initial begin
    cyc(1, 0, 0, 0, 4'h0, 16'h0, 0, 4'h0, 0);
    cyc(1, 0, 0, 0, 4'h0, 16'h0, 0, 4'h0, 0);
    chk_state("reset", 0, 0, 16'h0000, 4'h0, 3'b000);

    cyc(0, 0, 0, 1, 4'h0, 16'h7FFF, 1, 4'h5, 1);
    chk_state("add_possat", 1, 1, 16'h7FFF, 4'h5, 3'b010);

    cyc(0, 0, 0, 1, 4'h1, 16'h0000, 0, 4'h3, 1);
    chk_state("sub_zero", 1, 1, 16'h0000, 4'h3, 3'b100);

    cyc(0, 0, 0, 1, 4'h0, 16'h8000, 1, 4'h1, 0);
    chk_state("add_negsat", 1, 0, 16'h8000, 4'h1, 3'b011);
    cyc(0, 0, 0, 1, 4'h2, 16'h0000, 1, 4'h2, 1);
    chk_state("xor_zero", 1, 1, 16'h0000, 4'h2, 3'b111);

    cyc(0, 0, 0, 1, 4'h7, 16'h0042, 0, 4'h4, 1);
    chk_state("other_op", 1, 1, 16'h0042, 4'h4, 3'b111);
    cyc(0, 0, 0, 0, 4'h0, 16'h0001, 0, 4'h6, 1);
    chk_state("invalid_add", 0, 0, 16'h0001, 4'h6, 3'b111);

    cyc(0, 0, 0, 1, 4'h0, 16'h0005, 0, 4'h7, 1);
    chk_state("add_small", 1, 1, 16'h0005, 4'h7, 3'b000);
    for (int i = 0; i < 3; i++) begin
      cyc(0, 1, 0, 1, 4'h0, 16'h1234, 0, 4'h9, 1);
      chk_state("stall_hold", 1, 1, 16'h0005, 4'h7, 3'b000);
    end
    cyc(0, 0, 0, 1, 4'h0, 16'h1234, 0, 4'h9, 1);
    chk_state("stall_release", 1, 1, 16'h1234, 4'h9, 3'b000);

    cyc(0, 1, 1, 1, 4'h0, 16'h0000, 0, 4'hA, 1);
    chk_state("flush_stall", 0, 0, 16'h1234, 4'h9, 3'b000);

    cyc(0, 0, 0, 1, 4'h1, 16'hC321, 1, 4'h2, 1);
    chk_state("sub_neg", 1, 1, 16'hC321, 4'h2, 3'b011);
    cyc(1, 1, 0, 1, 4'h0, 16'h5555, 0, 4'hB, 1);
    chk_state("rst_in_stall", 0, 0, 16'h0000, 4'h0, 3'b000);

    in_valid = 1; in_op = 4'h0; in_result = 16'hFFFF; in_ovfl = 0; in_dst = 4'h1; in_wen = 1;
    #1;
`ifdef FLAG_BYPASS_EN
    chk("bypass flag_n", {31'd0, flag_n}, 32'd1);
`else
    chk("registered flag_n", {31'd0, flag_n}, 32'd0);
`endif
    cyc(0, 0, 0, 1, 4'h0, 16'hFFFF, 0, 4'h1, 1);
    chk_state("add_ffff", 1, 1, 16'hFFFF, 4'h1, 3'b001);

    for (int i = 0; i < 60; i++) begin
      cyc($urandom_range(0, 15) == 0, $urandom_range(0, 3) == 0, $urandom_range(0, 4) == 0,
          $urandom_range(0, 3) != 0, 4'($urandom_range(0, 4)),
          ($urandom_range(0, 3) == 0) ? 16'h0 : 16'($urandom), 1'($urandom),
          4'($urandom), 1'($urandom));
    end

    @(negedge clk);
    #1;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
